audio_out_mc: RTL

AUDIO_OUT_MC -- requirements
Module: audio_out_mc

---
 rtl/audio_out_mc.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/audio_out_mc.sv
// Multichannel audio output: frame FIFO feeding per-channel PCM registers that
// are rendered by first-order delta-sigma modulators, one frame per PERIOD cycles.
module audio_out_mc #(
    parameter int AUDIO_BITS       = 12,
    parameter int CHANNELS         = 2,
    parameter int FIFO_DEPTH       = 4,
    parameter int PERIOD           = 4096,
    parameter int PRIME_LEVEL      = 2,
    parameter int HOLD_ON_UNDERRUN = 0,
    parameter int SILENCE          = 0
) (
    input  logic                           clk_audio,
    input  logic                           aclr,
    input  logic                           enable,
    input  logic                           s_valid,
    input  logic [CHANNELS*AUDIO_BITS-1:0] s_data,
    output logic                           s_ready,
    output logic [CHANNELS-1:0]            dac_out,
    output logic                           frame_tick,
    output logic                           running,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    input  logic                           underrun_clr,
    output logic [15:0]                    underrun_count
);

    localparam int FW = CHANNELS * AUDIO_BITS;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [AUDIO_BITS-1:0] SIL         = AUDIO_BITS'(SILENCE);
    localparam logic [LW-1:0]         LEVEL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]         LEVEL_PRIME = LW'(PRIME_LEVEL);
    localparam logic [CW-1:0]         CNT_LAST    = CW'(PERIOD - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [FW-1:0]         mem_q [FIFO_DEPTH];
    logic [FW-1:0]         mem_d [FIFO_DEPTH];
    logic [AUDIO_BITS-1:0] pcm_q [CHANNELS];
    logic [AUDIO_BITS-1:0] pcm_d [CHANNELS];
    logic [AUDIO_BITS-1:0] acc_q [CHANNELS];
    logic [AUDIO_BITS-1:0] acc_d [CHANNELS];
    logic [AUDIO_BITS:0]   sum   [CHANNELS];
    logic [CHANNELS-1:0]   dac_q, dac_d;
    logic                  tick_q, tick_d;
    logic [15:0]           under_q, under_d;
    logic                  boundary, push, pop;

    // State register plus all datapath flops; aclr discards everything in flight.
    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dac_q    <= '0;
            tick_q   <= 1'b0;
            under_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                pcm_q[k] <= SIL;
                acc_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dac_q    <= dac_d;
            tick_q   <= tick_d;
            under_q  <= under_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
            for (int k = 0; k < CHANNELS; k++) begin
                pcm_q[k] <= pcm_d[k];
                acc_q[k] <= acc_d[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (level_q >= LEVEL_PRIME) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        running        = (state_q == RUN);
        s_ready        = (state_q != IDLE) && (level_q < LEVEL_FULL);
        frame_tick     = tick_q;
        fifo_level     = level_q;
        underrun_count = under_q;
        dac_out        = dac_q;
    end

    // The PRIME->RUN edge counts as a boundary so the first frame plays at once.
    always_comb begin
        boundary = enable && (((state_q == RUN) && (cnt_q == CNT_LAST)) ||
                              ((state_q == PRIME) && (level_q >= LEVEL_PRIME)));
        push     = enable && s_valid && s_ready;
        pop      = boundary && (level_q != '0);
        tick_d   = boundary;

        cnt_d = '0;
        if (enable && (state_q == RUN) && (cnt_q != CNT_LAST)) cnt_d = cnt_q + CW'(1);
    end

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (!enable) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = s_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
        end
    end

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            pcm_d[k] = pcm_q[k];
            if (!enable) begin
                pcm_d[k] = SIL;
            end else if (pop) begin
                pcm_d[k] = mem_q[rd_ptr_q][(CHANNELS-k)*AUDIO_BITS-1 -: AUDIO_BITS];
            end else if (boundary && (HOLD_ON_UNDERRUN == 0)) begin
                pcm_d[k] = SIL;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_comb begin
        under_d = under_q;
        if (underrun_clr) begin
            under_d = '0;
        end else if (boundary && (level_q == '0) && (under_q != 16'hFFFF)) begin
            under_d = under_q + 16'd1;
        end
    end

    always_comb begin
        dac_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum[k]   = {1'b0, acc_q[k]} + {1'b0, pcm_q[k]};
            acc_d[k] = sum[k][AUDIO_BITS-1:0];
            dac_d[k] = sum[k][AUDIO_BITS];
        end
    end

endmodule
